// File: rtl/phase_adjust_scheduler_pkg.sv
// Shared types and default sizing for the phase-adjust scheduler.
// Holds the FSM state enum and the default width/step/guard constants.
package phase_adjust_scheduler_pkg;

  localparam int unsigned PAS_NUM_REQ      = 4;
  localparam int unsigned PAS_PHASE_WIDTH  = 12;
  localparam int unsigned PAS_MAX_STEP     = 256;
  localparam int unsigned PAS_GUARD_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STROBE,
    S_HOLD,
    S_GUARD
  } pas_state_t;

endpackage

// File: rtl/phase_adjust_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick over a valid vector starting at ptr.
// Ports: valid/ptr in; one-hot grant, winner idx and any-valid out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!any && valid[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/phase_adjust_scheduler.sv
// Phase-adjust scheduler: arbitrates offset requests and drives the
// adder's en/strobe/phaseadd; ports i_clk, i_rst_n (sync, active-low),
// i_req_valid/i_req_phase in, o_req_ready, o_adj_en, o_adj_strobe,
// o_phaseadd, o_busy, o_grant_id out.
// PHASE_SCHED_STEP_LIMIT_EN: split offsets into steps of <= P_MAX_STEP.
module phase_adjust_scheduler
  import phase_adjust_scheduler_pkg::*;
#(
  parameter int P_NUM_REQ      = PAS_NUM_REQ,
  parameter int P_PHASE_WIDTH  = PAS_PHASE_WIDTH,
  parameter int P_MAX_STEP     = PAS_MAX_STEP,
  parameter int P_GUARD_CYCLES = PAS_GUARD_CYCLES,
  parameter int IW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [P_NUM_REQ-1:0]           i_req_valid,
  input  logic [P_NUM_REQ*P_PHASE_WIDTH-1:0] i_req_phase,
  output logic [P_NUM_REQ-1:0]           o_req_ready,
  output logic                           o_adj_en,
  output logic                           o_adj_strobe,
  output logic [P_PHASE_WIDTH-1:0]       o_phaseadd,
  output logic                           o_busy,
  output logic [IW-1:0]                  o_grant_id
);

  localparam int W = P_PHASE_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(P_NUM_REQ - 1);
  localparam logic [3:0] GLAST = 4'(P_GUARD_CYCLES - 1);

  pas_state_t state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic [3:0] gcnt_q;

  logic [P_NUM_REQ-1:0] win_gnt;
  logic [IW-1:0] win_idx;
  logic win_any;
  logic accept;
  logic [W-1:0] acc_phase;
  logic [W-1:0] step_w;
  logic more_c;

  logic en_d, strobe_d, busy_d;
  logic [W-1:0] phaseadd_d;

  rr_arbiter #(
    .N  (P_NUM_REQ),
    .IW (IW)
  ) u_arb (
    .valid (i_req_valid),
    .ptr   (ptr_q),
    .grant (win_gnt),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign accept = (state_q == S_IDLE) && win_any;
  assign o_req_ready =
    win_gnt & {P_NUM_REQ{(state_q == S_IDLE) && i_rst_n}};

  always_comb begin
    acc_phase = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (win_gnt[i]) acc_phase = i_req_phase[i*W +: W];
    end
  end

`ifdef PHASE_SCHED_STEP_LIMIT_EN
  // rem needs W+1 bits so that |-2^(W-1)| is representable.
  localparam logic [W:0] MAX_STEP = (W+1)'(P_MAX_STEP);
  logic [W:0] rem_q, abs_c, mag_c, step_c;

  always_comb begin
    abs_c  = rem_q[W] ? (~rem_q + 1'b1) : rem_q;
    mag_c  = (abs_c > MAX_STEP) ? MAX_STEP : abs_c;
    step_c = rem_q[W] ? (~mag_c + 1'b1) : mag_c;
  end

  assign step_w = step_c[W-1:0];
  assign more_c = |rem_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rem_q <= '0;
    end else if (accept) begin
      rem_q <= {acc_phase[W-1], acc_phase};
    end else if (state_q == S_STROBE) begin
      rem_q <= rem_q - step_c;
    end
  end
`else
  logic [W-1:0] off_q;

  assign step_w = off_q;
  assign more_c = 1'b0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      off_q <= '0;
    end else if (accept) begin
      off_q <= acc_phase;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gcnt_q       <= '0;
      o_grant_id   <= '0;
      o_adj_en     <= 1'b0;
      o_adj_strobe <= 1'b0;
      o_phaseadd   <= '0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gcnt_q       <= (state_q == S_GUARD) ? gcnt_q + 4'd1 : 4'd0;
      o_adj_en     <= en_d;
      o_adj_strobe <= strobe_d;
      o_phaseadd   <= phaseadd_d;
      o_busy       <= busy_d;
      if (accept) begin
        o_grant_id <= win_idx;
        ptr_q      <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept && (acc_phase != '0)) state_d = S_ARM;
      S_ARM:    state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_GUARD;
      S_GUARD:
        if (gcnt_q == GLAST) state_d = more_c ? S_ARM : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the
  // pins line up with the state they belong to.
  always_comb begin
    en_d       = 1'b0;
    strobe_d   = 1'b0;
    phaseadd_d = '0;
    busy_d     = (state_d != S_IDLE);
    unique case (1'b1)
      (state_d == S_ARM):    en_d = 1'b1;
      (state_d == S_STROBE): begin
        en_d       = 1'b1;
        strobe_d   = 1'b1;
        phaseadd_d = step_w;
      end
      (state_d == S_HOLD):   en_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_phase_adjust_scheduler.sv
// Scoreboard bench for phase_adjust_scheduler.
// Directed requests push expected strobes/grants/busy lengths to queues.
module tb_phase_adjust_scheduler;

  localparam int N = 4;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] valid = '0;
  logic [N*W-1:0] phase = '0;
  logic [N-1:0] ready;
  logic en, strobe, busy;
  logic [W-1:0] padd;
  logic [1:0] gid;

  phase_adjust_scheduler dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (valid),
    .i_req_phase  (phase),
    .o_req_ready  (ready),
    .o_adj_en     (en),
    .o_adj_strobe (strobe),
    .o_phaseadd   (padd),
    .o_busy       (busy),
    .o_grant_id   (gid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] strobe_q[$];
  int busy_q[$];
  int grant_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic en1 = 0, en2 = 0, s1 = 0, s2 = 0, rp1 = 0, rp2 = 0;
  logic pacc = 0;
  int pidx = 0;
  int brun = 0;

  always @(negedge clk) begin
    int aidx;
    aidx = -1;
    if (strobe) begin
      check("strobe_needs_en", en, 1);
      check("en_rise", {en1, en2}, 2'b10);
      if (strobe_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got %0h expected none", padd);
      end else begin
        check("phaseadd", padd, strobe_q.pop_front());
      end
    end
    if (s1 && rp1)
      check("en_hold", {en, strobe, padd}, {1'b1, 1'b0, 12'h000});
    if (s2 && rp1 && rp2)
      check("en_fall", en, 0);
    if (busy) begin
      brun++;
    end else if (brun > 0) begin
      if (busy_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL busy_len: got %0d expected none", brun);
      end else begin
        check("busy_len", brun, busy_q.pop_front());
      end
      brun = 0;
    end
    if (pacc && rp1) check("grant_id", gid, pidx);
    if (|(valid & ready) && rst_n) begin
      for (int i = 0; i < N; i++) if (ready[i]) aidx = i;
      if (grant_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL grant_order: got %0d expected none", aidx);
      end else begin
        check("grant_order", aidx, grant_q.pop_front());
      end
    end
    pacc = (aidx >= 0);
    pidx = aidx;
    en2 = en1;
    en1 = en;
    s2 = s1;
    s1 = strobe;
    rp2 = rp1;
    rp1 = rst_n;
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept(output int idx, output int n);
    idx = -1;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n = i;
      if (|(valid & ready)) begin
        for (int j = 0; j < N; j++) if (ready[j]) idx = j;
        break;
      end
    end
    if (idx < 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got none expected accept");
    end else begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_ph(int k, logic [W-1:0] v);
    phase[k*W +: W] = v;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_en"}, en, 0);
    check({tag, "_strobe"}, strobe, 0);
    check({tag, "_phaseadd"}, padd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_gid"}, gid, 0);
    check({tag, "_ready"}, ready, 0);
  endtask

  initial begin
    int idx, n, cnt, target;

    // Reset with all requests pending.
    set_ph(0, 12'h005);
    set_ph(1, 12'hFF9);
    set_ph(2, 12'h064);
    set_ph(3, 12'hFFF);
    valid = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");

    // Continuous valids: order 0,1,2,3,0.
    grant_q.push_back(0); strobe_q.push_back(12'h005); busy_q.push_back(7);
    grant_q.push_back(1); strobe_q.push_back(12'hFF9); busy_q.push_back(7);
    grant_q.push_back(2); strobe_q.push_back(12'h064); busy_q.push_back(7);
    grant_q.push_back(3); strobe_q.push_back(12'hFFF); busy_q.push_back(7);
    grant_q.push_back(0); strobe_q.push_back(12'h005); busy_q.push_back(7);
    rst_n = 1'b1;
    for (int r = 0; r < 5; r++) wait_accept(idx, n);
    valid = '0;

    // +600 from requester 1.
    set_ph(1, 12'h258);
    grant_q.push_back(1);
`ifdef PHASE_SCHED_STEP_LIMIT_EN
    strobe_q.push_back(12'h100);
    strobe_q.push_back(12'h100);
    strobe_q.push_back(12'h058);
    busy_q.push_back(21);
`else
    strobe_q.push_back(12'h258);
    busy_q.push_back(7);
`endif
    valid = 4'b0010;
    wait_accept(idx, n);
    valid = '0;

    // Most negative offset from requester 3.
    set_ph(3, 12'h800);
    grant_q.push_back(3);
`ifdef PHASE_SCHED_STEP_LIMIT_EN
    for (int s = 0; s < 8; s++) strobe_q.push_back(12'hF00);
    busy_q.push_back(56);
`else
    strobe_q.push_back(12'h800);
    busy_q.push_back(7);
`endif
    valid = 4'b1000;
    wait_accept(idx, n);
    valid = '0;

    // Requester 2 withdraws before its turn.
    set_ph(0, 12'h003);
    set_ph(1, 12'h004);
    set_ph(2, 12'h005);
    set_ph(3, 12'h006);
    grant_q.push_back(0); strobe_q.push_back(12'h003); busy_q.push_back(7);
    grant_q.push_back(1); strobe_q.push_back(12'h004); busy_q.push_back(7);
    grant_q.push_back(3); strobe_q.push_back(12'h006); busy_q.push_back(7);
    valid = 4'hF;
    wait_accept(idx, n);
    valid[0] = 1'b0;
    wait_accept(idx, n);
    valid[1] = 1'b0;
    valid[2] = 1'b0;
    wait_accept(idx, n);
    valid = '0;

    // Zero offset then an immediate second accept.
    set_ph(0, 12'h000);
    set_ph(1, 12'h009);
    grant_q.push_back(0);
    grant_q.push_back(1); strobe_q.push_back(12'h009); busy_q.push_back(7);
    valid = 4'b0011;
    wait_accept(idx, n);
    valid[0] = 1'b0;
    wait_accept(idx, n);
    check("zero_back2back_wait", n, 0);
    valid = '0;

    // Reset in the middle of a multi-step request.
    for (int i = 0; i < 200 && busy; i++) @(posedge clk);
    #2;
    set_ph(1, 12'h258);
    grant_q.push_back(1);
`ifdef PHASE_SCHED_STEP_LIMIT_EN
    strobe_q.push_back(12'h100);
    strobe_q.push_back(12'h100);
    busy_q.push_back(9);
    target = 2;
`else
    strobe_q.push_back(12'h258);
    busy_q.push_back(2);
    target = 1;
`endif
    valid = 4'b0010;
    wait_accept(idx, n);
    valid = '0;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < target; i++) begin
      @(posedge clk);
      #2;
      if (strobe) cnt++;
    end
    check("midreset_strobes_seen", cnt, target);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #2;

    check("strobes_left", strobe_q.size(), 0);
    check("busy_left", busy_q.size(), 0);
    check("grants_left", grant_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
